// File: rtl/sipo_framed_param_if.sv
// Output word handshake between the deserializer and a word consumer.
// The master (deserializer) drives the word and its valid flag; the slave
// (consumer) drives pready.
interface sipo_framed_param_if #(
   parameter int WIDTH = 10
) ();
   logic [WIDTH-1:0] Pdata;
   logic             pvalid;
   logic             pready;

   modport master (output Pdata, output pvalid, input pready);
   modport slave  (input Pdata, input pvalid, output pready);
endinterface

// File: rtl/sipo_framed_param.sv
// Framed serial-in/parallel-out deserializer.
// Serial bits qualified by shift_en are collected into WIDTH-bit words; a
// sync pulse restarts framing. Completed words go to a holding register
// offered downstream via valid/ready, and a dropped word sets a sticky
// overrun flag.
module sipo_framed_param #(
   parameter int WIDTH     = 10,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit REQ_SYNC  = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Sdata,
   input  logic                 shift_en,
   input  logic                 sync,
   input  logic                 ovr_clr,
   output logic                 overrun,
   output logic [CW-1:0]        bit_cnt,
   sipo_framed_param_if.master  pout
);

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      SHIFT     = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] pdata_reg, pdata_next;
   logic             pvalid_reg, pvalid_next;
   logic             overrun_reg, overrun_next;
   logic [WIDTH-1:0] shifted;

   // Shift register contents after taking Sdata; at completion this is also the finished word
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {shift_reg[WIDTH-2:0], Sdata};
      end else begin : g_lsb_first
         assign shifted = {Sdata, shift_reg[WIDTH-1:1]};
      end
   endgenerate

   // State and datapath registers; reset discards partial and pending words
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= REQ_SYNC ? WAIT_SYNC : SHIFT;
         shift_reg   <= '0;
         cnt_reg     <= '0;
         pdata_reg   <= '0;
         pvalid_reg  <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         cnt_reg     <= cnt_next;
         pdata_reg   <= pdata_next;
         pvalid_reg  <= pvalid_next;
         overrun_reg <= overrun_next;
      end
   end

   // Framing FSM, bit counting, word completion, handshake and overrun tracking
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      cnt_next     = cnt_reg;
      pdata_next   = pdata_reg;
      // An accept frees the holding register; a completion below may refill it
      pvalid_next  = pvalid_reg & ~pready_in();
      // A new drop on this edge overrides a simultaneous clear
      overrun_next = overrun_reg & ~ovr_clr;

      case (state_reg)
         WAIT_SYNC: begin
            if (sync) begin
               state_next = SHIFT;
               if (shift_en) begin
                  shift_next = shifted;
                  cnt_next   = ONE;
               end else begin
                  cnt_next   = '0;
               end
            end
         end
         SHIFT: begin
            if (sync) begin
               // Restart the frame; a word that would complete here is discarded
               if (shift_en) begin
                  shift_next = shifted;
                  cnt_next   = ONE;
               end else begin
                  cnt_next   = '0;
               end
            end else if (shift_en) begin
               shift_next = shifted;
               if (cnt_reg == LAST_BIT) begin
                  cnt_next = '0;
                  if (!pvalid_reg || pready_in()) begin
                     pdata_next  = shifted;
                     pvalid_next = 1'b1;
                  end else begin
                     overrun_next = 1'b1;
                  end
               end else begin
                  cnt_next = cnt_reg + ONE;
               end
            end
         end
         default: begin
            state_next = SHIFT;
         end
      endcase
   end

   function automatic logic pready_in();
      return pout.pready;
   endfunction

   assign pout.Pdata  = pdata_reg;
   assign pout.pvalid = pvalid_reg;
   assign overrun     = overrun_reg;
   assign bit_cnt     = cnt_reg;

endmodule
